demux2_stream: RTL and testbench
================================

DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 The block SHALL have parameter SIZE, default 10, giving the sample width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, SIZE bits, signed: the incoming sample.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data/in_sel are valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-007 The block SHALL have port in_sel, input, 1 bit: the destination channel when mode=0 (0->out0, 1->out1).
REQ-008 The block SHALL have port mode, input, 1 bit: 0=explicit select, 1=alternating even/odd routing.
REQ-009 The block SHALL have ports out0_data/out1_data, output, SIZE bits, signed: the registered channel samples.
REQ-010 The block SHALL have ports out0_valid/out1_valid, output, 1 bit each: the channel register holds a sample.
REQ-011 The block SHALL have ports out0_ready/out1_ready, input, 1 bit each: the downstream consumes the channel sample.
REQ-012 The block SHALL have port pair_done, output, 1 bit: a one-cycle pulse when an odd sample completes a pair in mode=1.

Function
REQ-013 The destination dest SHALL be in_sel when mode=0 and the internal toggle bit tgl when mode=1.
REQ-014 in_ready SHALL be combinational: high when the dest channel register is empty or that channel's valid and ready are both high this cycle.
REQ-015 Accept SHALL occur when in_valid and in_ready are both high; only accepted samples change state.
REQ-016 On accept, the dest channel register SHALL load in_data unmodified (no width change or sign change) and set its valid at the next edge; latency is 1 cycle from accept to outN_valid.
REQ-017 Channel drain SHALL occur when outN_valid and outN_ready are both high; on drain without a simultaneous load, outN_valid SHALL clear next cycle.
REQ-018 A simultaneous drain and load on the same channel SHALL keep outN_valid high with the new data; there SHALL be no bubble and no loss.
REQ-019 outN_data SHALL hold its value while outN_valid is high and no drain occurs; it SHALL also hold after a drain until the next load.
REQ-020 The non-destination channel SHALL be unaffected by an accept and SHALL drain independently in the same cycle.
REQ-021 In mode=1, tgl SHALL invert on every accept (0->1->0), wrapping naturally; the first sample after reset goes to out0.
REQ-022 In mode=0, tgl SHALL hold its value; on any cycle where mode differs from its registered previous value, tgl SHALL clear to 0, so each alternating run starts on out0.
REQ-023 pair_done SHALL pulse high for exactly one cycle, the cycle after an accept with mode=1 and tgl=1; otherwise it SHALL be 0.
REQ-024 When in_valid is high and in_ready is low, the block SHALL not change tgl or either channel register (backpressure stall); the upstream holds its inputs.
REQ-025 When in_valid is low, no state SHALL change except channel drains.

Reset
REQ-026 With rst high at an edge, out0_valid, out1_valid, pair_done, tgl and the registered mode SHALL become 0, and out0_data and out1_data SHALL become 0.
REQ-027 rst SHALL take priority over accept and drain in the same cycle; held samples SHALL be discarded mid-operation.
REQ-028 In the first cycle after reset, in_ready SHALL be 1 for either dest.

Verification
REQ-029 Scenario: reset, then mode=1 with samples 5, -3, 7, -8, both readys=1 -> out0 shows 5 then 7, out1 shows -3 then -8, one cycle after each accept; pair_done pulses after -3 and after -8.
REQ-030 Scenario: mode=0, in_sel=1, out1_ready=0, samples 100 then 200 -> 100 is accepted and in_ready goes low; 200 stalls; out1_data stays 100; out0_valid stays 0.
REQ-031 Scenario: out1 full and draining, with 200 offered to out1 in the same cycle -> accepted; out1_valid stays 1; out1_data=200 next cycle.
REQ-032 Scenario: SIZE=10 with samples -512 and 511 -> they appear bit-exact on the outputs.
REQ-033 Scenario: mode=1, one sample accepted (tgl=1), then mode is pulsed to 0 for one cycle and back to 1 -> the next sample routes to out0.
REQ-034 Scenario: rst asserted while both channels are valid and in_valid=1 -> next cycle both valids=0, data=0, pair_done=0, in_ready=1.

Source files
------------

// File: rtl/demux2_stream.sv
// ---------------------------------------------------------------------------
// demux2_stream
//   Routes a valid/ready sample stream to one of two registered output
//   channels. In explicit mode (mode=0) in_sel picks the channel; in
//   alternating mode (mode=1) an internal toggle sends even samples to out0
//   and odd samples to out1. pair_done pulses when an odd sample completes a
//   pair.
//
// Ports
//   clk                     : clock, all state updates on the rising edge
//   rst                     : synchronous active-high reset
//   in_data  [SIZE-1:0]     : incoming signed sample
//   in_valid                : in_data/in_sel valid this cycle
//   in_ready                : block accepts the input this cycle (combinational)
//   in_sel                  : destination channel when mode=0
//   mode                    : 0 = explicit select, 1 = alternating routing
//   out0_data/out1_data     : registered channel samples
//   out0_valid/out1_valid   : channel register holds a sample
//   out0_ready/out1_ready   : downstream consumes the channel sample
//   pair_done               : one-cycle pulse after the odd sample of a pair
// ---------------------------------------------------------------------------
module demux2_stream #(
  parameter int SIZE = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [SIZE-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sel,
  input  logic                   mode,
  output logic signed [SIZE-1:0] out0_data,
  output logic signed [SIZE-1:0] out1_data,
  output logic                   out0_valid,
  output logic                   out1_valid,
  input  logic                   out0_ready,
  input  logic                   out1_ready,
  output logic                   pair_done
);

  logic signed [SIZE-1:0] out0_data_q, out0_data_d;
  logic signed [SIZE-1:0] out1_data_q, out1_data_d;
  logic                   out0_valid_q, out0_valid_d;
  logic                   out1_valid_q, out1_valid_d;
  logic                   tgl_q, tgl_d;
  logic                   mode_q, mode_d;
  logic                   pair_done_q, pair_done_d;

  logic tgl_eff_s;
  logic dest_s;
  logic ch0_free_s;
  logic ch1_free_s;
  logic in_ready_s;
  logic accept_s;
  logic load0_s;
  logic load1_s;

  // Routing, handshake and next-state computation.
  always_comb begin
    tgl_eff_s    = 1'b0;
    dest_s       = 1'b0;
    ch0_free_s   = 1'b0;
    ch1_free_s   = 1'b0;
    in_ready_s   = 1'b0;
    accept_s     = 1'b0;
    load0_s      = 1'b0;
    load1_s      = 1'b0;
    out0_data_d  = out0_data_q;
    out1_data_d  = out1_data_q;
    out0_valid_d = out0_valid_q;
    out1_valid_d = out1_valid_q;
    tgl_d        = tgl_q;
    mode_d       = mode;
    pair_done_d  = 1'b0;

    // A mode change clears the toggle in the same cycle, so a sample offered
    // on the first cycle of a new alternating run already routes to out0.
    if (mode != mode_q) begin
      tgl_eff_s = 1'b0;
    end else begin
      tgl_eff_s = tgl_q;
    end

    if (mode) begin
      dest_s = tgl_eff_s;
    end else begin
      dest_s = in_sel;
    end

    // A channel can take a sample if empty or being drained this cycle.
    ch0_free_s = !out0_valid_q || out0_ready;
    ch1_free_s = !out1_valid_q || out1_ready;

    if (dest_s) begin
      in_ready_s = ch1_free_s;
    end else begin
      in_ready_s = ch0_free_s;
    end

    accept_s = in_valid && in_ready_s;
    load0_s  = accept_s && !dest_s;
    load1_s  = accept_s && dest_s;

    // Load wins over drain so a simultaneous drain+load leaves no bubble.
    if (load0_s) begin
      out0_valid_d = 1'b1;
      out0_data_d  = in_data;
    end else if (out0_valid_q && out0_ready) begin
      out0_valid_d = 1'b0;
    end else begin
      out0_valid_d = out0_valid_q;
    end

    if (load1_s) begin
      out1_valid_d = 1'b1;
      out1_data_d  = in_data;
    end else if (out1_valid_q && out1_ready) begin
      out1_valid_d = 1'b0;
    end else begin
      out1_valid_d = out1_valid_q;
    end

    if (accept_s && mode) begin
      tgl_d       = ~tgl_eff_s;
      pair_done_d = tgl_eff_s;
    end else begin
      tgl_d       = tgl_eff_s;
      pair_done_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0_data_q  <= {SIZE{1'b0}};
      out1_data_q  <= {SIZE{1'b0}};
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      tgl_q        <= 1'b0;
      mode_q       <= 1'b0;
      pair_done_q  <= 1'b0;
    end else begin
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
      tgl_q        <= tgl_d;
      mode_q       <= mode_d;
      pair_done_q  <= pair_done_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out0_data  = out0_data_q;
  assign out1_data  = out1_data_q;
  assign out0_valid = out0_valid_q;
  assign out1_valid = out1_valid_q;
  assign pair_done  = pair_done_q;

endmodule

// File: tb/tb_demux2_stream.sv
// ---------------------------------------------------------------------------
// tb_demux2_stream
//   Directed, table-driven bench for demux2_stream (SIZE=10). Each record
//   holds the inputs for one cycle, the expected combinational in_ready
//   before the edge, and the expected registered outputs after the edge.
// ---------------------------------------------------------------------------
module tb_demux2_stream;

  localparam int SIZE = 10;

  logic                   clk;
  logic                   rst;
  logic signed [SIZE-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sel;
  logic                   mode;
  logic signed [SIZE-1:0] out0_data;
  logic signed [SIZE-1:0] out1_data;
  logic                   out0_valid;
  logic                   out1_valid;
  logic                   out0_ready;
  logic                   out1_ready;
  logic                   pair_done;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic            rst;
    logic            vld;
    logic            sel;
    logic            mode;
    logic [SIZE-1:0] data;
    logic            r0;
    logic            r1;
    logic            chk_rdy;
    logic            e_rdy;
    logic            e_v0;
    logic [SIZE-1:0] e_d0;
    logic            e_v1;
    logic [SIZE-1:0] e_d1;
    logic            e_pd;
  } vec_t;

  vec_t vecs[17];

  demux2_stream #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .mode       (mode),
    .out0_data  (out0_data),
    .out1_data  (out1_data),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .pair_done  (pair_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst_v, input logic vld, input logic sel, input logic md,
    input logic [SIZE-1:0] data, input logic r0, input logic r1,
    input logic chk_rdy, input logic e_rdy,
    input logic e_v0, input logic [SIZE-1:0] e_d0,
    input logic e_v1, input logic [SIZE-1:0] e_d1, input logic e_pd);
    vec_t v;
    v.rst = rst_v; v.vld = vld; v.sel = sel; v.mode = md; v.data = data;
    v.r0 = r0; v.r1 = r1; v.chk_rdy = chk_rdy; v.e_rdy = e_rdy;
    v.e_v0 = e_v0; v.e_d0 = e_d0; v.e_v1 = e_v1; v.e_d1 = e_d1; v.e_pd = e_pd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one record, check in_ready before the edge and outputs after it.
  task automatic apply(input vec_t v, input string tag);
    rst        = v.rst;
    in_valid   = v.vld;
    in_sel     = v.sel;
    mode       = v.mode;
    in_data    = v.data;
    out0_ready = v.r0;
    out1_ready = v.r1;
    #1;
    if (v.chk_rdy) chk({tag, ".in_ready"}, {{(SIZE-1){1'b0}}, in_ready}, {{(SIZE-1){1'b0}}, v.e_rdy});
    @(posedge clk);
    #1;
    chk({tag, ".out0_valid"}, {{(SIZE-1){1'b0}}, out0_valid}, {{(SIZE-1){1'b0}}, v.e_v0});
    chk({tag, ".out0_data"},  out0_data, v.e_d0);
    chk({tag, ".out1_valid"}, {{(SIZE-1){1'b0}}, out1_valid}, {{(SIZE-1){1'b0}}, v.e_v1});
    chk({tag, ".out1_data"},  out1_data, v.e_d1);
    chk({tag, ".pair_done"},  {{(SIZE-1){1'b0}}, pair_done}, {{(SIZE-1){1'b0}}, v.e_pd});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; mode = 1'b0;
    in_data = '0; out0_ready = 1'b1; out1_ready = 1'b1;

    //                rst   vld   sel   mode  data          r0    r1    chk   rdy   v0    d0            v1    d1            pd
    // reset
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0,        1'b0, 10'd0,        1'b0);
    // alternating: 5, -3, 7, -8
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 10'd5,        1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd5,        1'b0, 10'd0,        1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b1, -10'sd3,      1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd5,        1'b1, -10'sd3,      1'b1);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 10'd7,        1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd7,        1'b0, -10'sd3,      1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b1, -10'sd8,      1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd7,        1'b1, -10'sd8,      1'b1);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 10'd0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd7,        1'b0, -10'sd8,      1'b0);
    // explicit select to out1 with out1 stalled: 100 accepted, 200 stalls
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 10'd100,      1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd7,        1'b1, 10'd100,      1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 10'd200,      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd7,        1'b1, 10'd100,      1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 10'd200,      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd7,        1'b1, 10'd100,      1'b0);
    // out1 drains while 200 loads: no bubble
    vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 10'd200,      1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd7,        1'b1, 10'd200,      1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 10'd0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd7,        1'b0, 10'd200,      1'b0);
    // extremes -512 / 511, then a stall on full out0
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'h200,      1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'h200,      1'b0, 10'd200,      1'b0);
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 1'b0, 10'h1FF,      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h200,      1'b1, 10'h1FF,      1'b0);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd3,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h200,      1'b1, 10'h1FF,      1'b0);
    // reset while both channels full and input offered
    vecs[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'd3,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,        1'b0, 10'd0,        1'b0);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0,        1'b0, 10'd0,        1'b0);
    vecs[16] = mk(1'b0, 1'b0, 1'b1, 1'b0, 10'd0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0,        1'b0, 10'd0,        1'b0);

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Mode pulsed to 0 for one cycle mid-pair: next alternating sample
    // restarts on out0, and the following one completes a pair on out1.
    apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 10'd11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd11, 1'b0, 10'd0,  1'b0), "modepulse_a");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd11, 1'b0, 10'd0,  1'b0), "modepulse_b");
    apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 10'd22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'd22, 1'b0, 10'd0,  1'b0), "modepulse_c");
    apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 10'd33, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd22, 1'b1, 10'd33, 1'b1), "modepulse_d");
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 10'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd22, 1'b0, 10'd33, 1'b0), "modepulse_e");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
